// File: rtl/regfile_mp_if.sv
// Bundle of the register file's decode/writeback-facing signals.
// The master side (decode/writeback) drives requests; the slave side
// (the register file) returns read data, readiness and the scoreboard.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 4
);
  logic                        we0;
  logic [ADDR_W-1:0]           waddr0;
  logic [DATA_W-1:0]           wdata0;
  logic                        we1;
  logic [ADDR_W-1:0]           waddr1;
  logic [DATA_W-1:0]           wdata1;
  logic [NREAD-1:0]            re;
  logic [NREAD*ADDR_W-1:0]     raddr;
  logic [NREAD*DATA_W-1:0]     rdata;
  logic [NREAD-1:0]            rrdy;
  logic [1:0]                  sb_set;
  logic [2*ADDR_W-1:0]         sb_addr;
  logic                        sb_clr0;
  logic                        sb_clr1;
  logic                        flush;
  logic [(1<<ADDR_W)-1:0]      pending;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output re, raddr, sb_set, sb_addr, sb_clr0, sb_clr1, flush,
    input  rdata, rrdy, pending
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  re, raddr, sb_set, sb_addr, sb_clr0, sb_clr1, flush,
    output rdata, rrdy, pending
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two write
// ports with same-cycle bypass (port 1 is the younger slot and wins),
// and a per-register pending scoreboard used by decode to stall.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 4,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_set;
  logic [DEPTH-1:0]  w_clr;
  logic              w_wr0_ok;
  logic              w_wr1_ok;

  // Writes to the hardwired zero register are discarded.
  assign w_wr0_ok = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign w_wr1_ok = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));

  // Array update; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[bus.waddr0] <= bus.wdata0;
      if (w_wr1_ok) r_mem[bus.waddr1] <= bus.wdata1;
    end
  end

  // Decode scoreboard set/clear requests into per-entry vectors.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.sb_clr0 && (bus.waddr0 == ADDR_W'(i))) w_clr[i] = 1'b1;
      if (bus.sb_clr1 && (bus.waddr1 == ADDR_W'(i))) w_clr[i] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (bus.sb_set[k] && (bus.sb_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)))
          w_set[i] = 1'b1;
      end
    end
    if (ZERO_REG != 0) w_set[0] = 1'b0;
  end

  // Scoreboard state: a new producer (set) overrides a retiring one (clear);
  // flush drops everything including same-cycle sets.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign bus.pending = r_pending;

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_re;
      logic [DATA_W-1:0] w_data;
      logic              w_retiring;

      assign w_addr = bus.raddr[gi*ADDR_W +: ADDR_W];
      assign w_re   = bus.re[gi];

      // Read mux in priority order: reset, disabled, zero reg, bypass, array.
      always_comb begin
        if (rst || !w_re)                                w_data = '0;
        else if ((ZERO_REG != 0) && (w_addr == '0))      w_data = '0;
        else if (bus.we1 && (bus.waddr1 == w_addr))      w_data = bus.wdata1;
        else if (bus.we0 && (bus.waddr0 == w_addr))      w_data = bus.wdata0;
        else                                             w_data = r_mem[w_addr];
      end

      // A producer writing back this cycle is bypassed, so it is ready.
      assign w_retiring = (bus.sb_clr0 && bus.we0 && (bus.waddr0 == w_addr)) ||
                          (bus.sb_clr1 && bus.we1 && (bus.waddr1 == w_addr));

      assign bus.rdata[gi*DATA_W +: DATA_W] = w_data;
      assign bus.rrdy[gi] = rst || !w_re || !r_pending[w_addr] || w_retiring;
    end
  endgenerate
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the dual-issue core, the next generation of the single-issue register file. It provides NREAD combinational read ports and two write ports with same-cycle write-to-read bypass, and a per-register pending scoreboard. The decode stage uses the scoreboard to stall on in-flight producers. The block sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NREAD, 4, number of read ports (1..8)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and scoreboard sets

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we0  in  1  write port 0 enable (older writeback slot)
- waddr0  in  ADDR_W  write port 0 address
- wdata0  in  DATA_W  write port 0 data
- we1  in  1  write port 1 enable (younger writeback slot)
- waddr1  in  ADDR_W  write port 1 address
- wdata1  in  DATA_W  write port 1 data
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W]
- rrdy  out  NREAD  port i operand is valid (no unresolved producer)
- sb_set  in  2  per-issue-slot scoreboard set request
- sb_addr  in  2*ADDR_W  packed destination addresses for sb_set
- sb_clr0 / sb_clr1  in  1 each  clear pending bit of waddr0 / waddr1 (asserted with we0/we1 for tracked writes)
- flush  in  1  clear entire scoreboard next edge (registers untouched)
- pending  out  2^ADDR_W  raw scoreboard vector for debug/hazard unit

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus a 2^ADDR_W pending vector.
- Write: on the edge, when weK is high and the address is not the zero register, write wdataK to waddrK. When both ports target the same address, port 1 wins.
- Read port i, evaluated combinationally in priority order:
  - rst high -> 0.
  - re[i] low -> 0.
  - addr 0 with ZERO_REG=1 -> 0.
  - we1 high and waddr1 matches -> wdata1.
  - we0 high and waddr0 matches -> wdata0.
  - Otherwise the stored value.
- Scoreboard next-state per entry: pending' = (pending & ~clr) | set.
  - clr comes from sb_clrK with a matching waddrK.
  - set comes from any sb_set[k] with a matching sb_addr.
  - Set beats clear on the same entry, because a new producer supersedes a retiring one.
  - Sets to register 0 are ignored when ZERO_REG=1.
  - flush forces all bits to 0. Sets in the same cycle as flush are dropped.
- rrdy[i] = ~re[i] | ~pending[raddr_i] | (sb_clrK & weK & waddrK == raddr_i, for any K).
  - A producer retiring this cycle counts as ready because its data is bypassed.
  - rrdy is 1 during rst.
- Reset: all registers to 0 and pending to 0 on the edge with rst high. rst has priority over writes, sets, clears and flush.

## Timing
- Read latency 0 cycles (combinational). A write becomes visible in the same cycle via bypass and from the array in the next cycle.
- Scoreboard latency:
  - A set in cycle N is visible on pending and rrdy from cycle N+1.
  - A clear takes effect on rrdy in cycle N and on pending in N+1.
- Reset outputs: rdata all 0, rrdy all 1, pending all 0.
- Reset asserted mid-operation: writes and sets in that cycle are lost, and the state is fully zeroed after one edge.
- No multi-cycle state machine. All state updates complete in a single edge.

## Test plan
- Reset: preload r5=0x1234, assert rst for 1 cycle -> every read returns 0x0, pending==0, rrdy all 1.
- Write/read with bypass: we0=1, waddr0=3, wdata0=0xDEADBEEF, raddr port0=3 in same cycle -> rdata0=0xDEADBEEF. Next cycle with we0=0 -> still 0xDEADBEEF.
- Write collision: we0/we1 both to r7 with 0x11/0x22 -> r7=0x22. Read in the same cycle also returns 0x22.
- Zero register: write 0xFFFFFFFF to r0 and sb_set on r0 -> read r0=0, pending[0]=0.
- Scoreboard:
  - sb_set slot0 r9 in cycle N -> rrdy for r9 is 0 in N+1.
  - we1+sb_clr1 on r9 with 0x55 in N+3 -> rrdy=1 and rdata=0x55 in N+3, pending[9]=0 in N+4.
  - Repeat with a set and clear of r9 in the same cycle -> pending[9] stays 1.
- Flush: set r4 and r12, then flush together with sb_set r6 -> pending all 0 next cycle and register contents unchanged.
